// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA timing types, standard mode constants and line/frame total helpers
package vga_timing_pkg;
  localparam bit POL_NEG = 1'b0;
  localparam bit POL_POS = 1'b1;
  typedef struct packed {
    logic hs;
    logic vs;
    logic von;
  } sync_t;
  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
    bit hs_pol;
    bit vs_pol;
  } vga_mode_t;
  localparam vga_mode_t MODE_640X480_60  = '{640, 16, 96, 48, 480, 10, 2, 33, POL_NEG, POL_NEG};
  localparam vga_mode_t MODE_800X600_60  = '{800, 40, 128, 88, 600, 1, 4, 23, POL_POS, POL_POS};
  localparam vga_mode_t MODE_1024X768_60 = '{1024, 24, 136, 160, 768, 3, 6, 29, POL_NEG, POL_NEG};
  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_sig_delay.sv
// vga_sig_delay: shift-enabled delay line with synchronous clear; zero depth is a plain wire
module vga_sig_delay #(
  parameter int DEPTH = 2,
  parameter int W = 3,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n, clr, shift};
    assign q = d;
  end else begin : g_sr
    localparam int SW = DEPTH * W;
    logic [SW-1:0] sr_q, sr_d;
    always_comb sr_d = clr ? {DEPTH{RST_VAL}} : shift ? SW'({sr_q, d}) : sr_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sr_q <= {DEPTH{RST_VAL}};
      else sr_q <= sr_d;
    assign q = sr_q[SW-1 -: W];
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: divided pixel tick, x/y counters, line/frame markers and
// sync/blank decode delayed by PIPE_DLY pixel ticks
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = POL_NEG,
  parameter bit VS_POL   = POL_NEG,
  parameter int CLK_DIV  = 4,
  parameter int PIPE_DLY = 2,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          pixel_tick,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_start,
  output logic          frame_start
);
  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_MAX  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam sync_t IDLE = '{hs: ~HS_POL, vs: ~VS_POL, von: 1'b0};

  if (H_TOTAL > 2 ** CW || V_TOTAL > 2 ** CW || CLK_DIV < 1 || PIPE_DLY < 0 || PIPE_DLY > 15)
  begin : g_param_check
    $error("vga_timing_gen: totals exceed CW bits or CLK_DIV/PIPE_DLY out of range");
  end

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic tick_q, tick_d, run_q, run_d, ls_q, ls_d, fs_q, fs_d;
  sync_t raw, dly, out_q, out_d;

  // run_q is clear until the restart tick, which holds the counters at 0,0
  always_comb begin
    tick_d = en && div_q == DIV_MAX;
    div_d  = (!en || tick_d) ? '0 : div_q + 1'b1;
    run_d  = en && (run_q || tick_d);
    x_d    = !en ? '0 : (!tick_d || !run_q) ? x_q : x_q == H_MAX ? '0 : x_q + 1'b1;
    y_d    = !en ? '0 : (!tick_d || !run_q || x_q != H_MAX) ? y_q : y_q == V_MAX ? '0 : y_q + 1'b1;
    ls_d   = tick_d && x_d == '0;
    fs_d   = ls_d && y_d == '0;
    raw.hs  = (x_d >= HS_BEG && x_d < HS_END) ? HS_POL : ~HS_POL;
    raw.vs  = (y_d >= VS_BEG && y_d < VS_END) ? VS_POL : ~VS_POL;
    raw.von = x_d < H_ACT && y_d < V_ACT;
    out_d  = !en ? IDLE : tick_d ? dly : out_q;
  end

  vga_sig_delay #(.DEPTH(PIPE_DLY), .W(3), .RST_VAL(IDLE)) u_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (!en),
    .shift(tick_d),
    .d    (raw),
    .q    (dly)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      run_q  <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
      out_q  <= IDLE;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      run_q  <= run_d;
      x_q    <= x_d;
      y_q    <= y_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
      out_q  <= out_d;
    end

  assign pixel_tick  = tick_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign hsync       = out_q.hs;
  assign vsync       = out_q.vs;
  assign video_on    = out_q.von;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
endmodule
